// File: rtl/ld_down_counter.sv
// ld_down_counter: loadable, cascadable down counter with borrow chain and registered terminal-count pulse.
// Define LD_DOWN_COUNTER_AUTORELOAD_EN to wrap to the last loaded value instead of all-ones.
module ld_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             CK,
   input  logic             CD,
   input  logic             SP,
   input  logic             SD,
   input  logic             BI,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             BO,
   output logic             TC
);
   logic [WIDTH-1:0] wrap;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] rld;
   always_ff @(posedge CK)
      if (CD) rld <= '0;
      else if (SP && SD) rld <= D;
   assign wrap = rld;
`else
   assign wrap = '1;
`endif
   assign BO = BI & (Q == '0);
   always_ff @(posedge CK)
      if (CD) begin
         Q  <= '0;
         TC <= 1'b0;
      end else if (SP) begin
         if (SD) begin
            Q  <= D;
            TC <= 1'b0;
         end else if (BI) begin
            Q  <= (Q == '0) ? wrap : Q - 1'b1;
            TC <= (Q == WIDTH'(1));
         end else
            TC <= 1'b0;
      end
endmodule

// File: tb/tb_ld_down_counter.sv
// tb_ld_down_counter: table-driven checks of the 4-bit slice plus cascade and WIDTH=1 sequences.
module tb_ld_down_counter;
`ifdef LD_DOWN_COUNTER_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   typedef struct {
      logic       cd, sp, sd, bi;
      logic [3:0] d, q;
      logic       tc, bo;
   } vec_t;

   logic       CK = 1'b0, CD, SP, SD, BI;
   logic [3:0] D, Q;
   logic       BO, TC;
   logic       csp, csd;
   logic [7:0] cd8;
   logic [3:0] qlo, qhi;
   logic       bolo, bohi, tclo, tchi;
   logic       wsp, wsd, wbi, wd, wq, wbo, wtc;
   int         total = 0, bad = 0;
   vec_t       v[$];

   always #5 CK = ~CK;

   ld_down_counter #(.WIDTH(4)) dut (.CK(CK), .CD(CD), .SP(SP), .SD(SD), .BI(BI), .D(D), .Q(Q), .BO(BO), .TC(TC));
   ld_down_counter #(.WIDTH(4)) lo (.CK(CK), .CD(CD), .SP(csp), .SD(csd), .BI(1'b1), .D(cd8[3:0]), .Q(qlo), .BO(bolo), .TC(tclo));
   ld_down_counter #(.WIDTH(4)) hi (.CK(CK), .CD(CD), .SP(csp), .SD(csd), .BI(bolo), .D(cd8[7:4]), .Q(qhi), .BO(bohi), .TC(tchi));
   ld_down_counter #(.WIDTH(1)) w1 (.CK(CK), .CD(CD), .SP(wsp), .SD(wsd), .BI(wbi), .D(wd), .Q(wq), .BO(wbo), .TC(wtc));

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   initial begin
      csp = 0; csd = 0; cd8 = 0; wsp = 0; wsd = 0; wbi = 0; wd = 0;
      //           cd sp sd bi d      q                    tc               bo
      v.push_back('{1, 1, 1, 1, 4'hA, 4'h0,                1'b0,            1'b1});
      v.push_back('{1, 1, 1, 1, 4'hA, 4'h0,                1'b0,            1'b1});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h0 : 4'hF,    1'b0,            AR});
      v.push_back('{0, 1, 1, 1, 4'h3, 4'h3,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h2,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h1,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h0,                1'b1,            1'b1});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h3 : 4'hF,    1'b0,            1'b0});
      v.push_back('{0, 1, 1, 1, 4'h2, 4'h2,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h1,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h0,                1'b1,            1'b1});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h2 : 4'hF,    1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h1 : 4'hE,    1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h0 : 4'hD,    AR,              AR});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h2 : 4'hC,    1'b0,            1'b0});
      v.push_back('{0, 1, 1, 1, 4'h0, 4'h0,                1'b0,            1'b1});
      v.push_back('{0, 1, 1, 1, 4'h5, 4'h5,                1'b0,            1'b0});
      v.push_back('{0, 0, 1, 1, 4'h9, 4'h5,                1'b0,            1'b0});
      v.push_back('{0, 1, 1, 1, 4'h1, 4'h1,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h0,                1'b1,            1'b1});
      v.push_back('{0, 0, 0, 1, 4'h0, 4'h0,                1'b1,            1'b1});
      v.push_back('{0, 1, 0, 0, 4'h0, 4'h0,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 0, 4'h0, 4'h0,                1'b0,            1'b0});
      v.push_back('{0, 1, 1, 1, 4'h9, 4'h9,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h8,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h7,                1'b0,            1'b0});
      v.push_back('{0, 1, 0, 1, 4'h0, 4'h6,                1'b0,            1'b0});
      v.push_back('{1, 1, 1, 1, 4'h3, 4'h0,                1'b0,            1'b1});
      v.push_back('{0, 1, 0, 1, 4'h0, AR ? 4'h0 : 4'hF,    1'b0,            AR});
      foreach (v[i]) begin
         CD = v[i].cd; SP = v[i].sp; SD = v[i].sd; BI = v[i].bi; D = v[i].d;
         step();
         chk($sformatf("v%0d.Q", i), Q, v[i].q);
         chk($sformatf("v%0d.TC", i), TC, v[i].tc);
         chk($sformatf("v%0d.BO", i), BO, v[i].bo);
      end
      SP = 0;
      // cascade: two 4-bit slices as one 8-bit counter
      csp = 1; csd = 1; cd8 = 8'h01;
      step();
      chk("casc.load", {qhi, qlo}, 8'h01);
      chk("casc.bo_load", bohi, 1'b0);
      csd = 0;
      step();
      chk("casc.zero", {qhi, qlo}, 8'h00);
      chk("casc.bo_zero", bohi, 1'b1);
      step();
      chk("casc.wrap", {qhi, qlo}, AR ? 8'h01 : 8'hFF);
      chk("casc.bo_wrap", bohi, 1'b0);
      csp = 0;
      // WIDTH=1 slice: 1 -> 0 -> wrap
      wsp = 1; wsd = 1; wd = 1; wbi = 1;
      step();
      chk("w1.load", wq, 1'b1);
      wsd = 0;
      step();
      chk("w1.zero", wq, 1'b0);
      chk("w1.tc", wtc, 1'b1);
      chk("w1.bo", wbo, 1'b1);
      step();
      chk("w1.wrap", wq, 1'b1);
      chk("w1.tc_wrap", wtc, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
